// File: rtl/riscv_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: opcodes, ALU
// control codes, mux select encodings and the FSM state type.
package riscv_multicycle_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL
    } state_t;

    // Operation class handed to the ALU decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_RTYPE,
        ALUOP_ITYPE
    } alu_op_t;

    // True for every opcode the control FSM knows how to sequence.
    function automatic logic is_supported(input logic [6:0] op);
        return (op == OP_LOAD)  || (op == OP_STORE)  || (op == OP_RTYPE) ||
               (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/riscv_alu_dec.sv
// ALU control decoder: maps operation class plus funct fields to an ALU code.
module riscv_alu_dec
    import riscv_multicycle_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] alu_control
);

    // Unrecognised funct3 values fall back to add so the ALU never sees an
    // undefined code.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct3)
                    3'b000:  alu_control = funct7_5 ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            ALUOP_ITYPE: begin
                alu_control = (funct3 == 3'b010) ? ALU_SLT : ALU_ADD;
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle control FSM for a shared-memory RISC-V datapath.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
//   DECODE   | latch branch target oldPC+immB, dispatch on opcode
//   MEMADR   | compute rs1+imm for load/store
//   MEMREAD  | load access, waits for mem_ready
//   MEMWB    | write loaded data to rd
//   MEMWRITE | store access, waits for mem_ready, ends the instruction
//   EXECR    | register-register ALU operation
//   EXECI    | register-immediate ALU operation
//   ALUWB    | write ALU-result register to rd
//   BRANCH   | rs1-rs2 compare, load PC with latched target when taken
//   JAL      | load PC with latched target, compute link value oldPC+4
module riscv_multicycle_ctrl
    import riscv_multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic       instr_done,
    output logic       illegal
);

    state_t     state_q;
    state_t     state_d;
    alu_op_t    alu_op;
    logic [2:0] alu_control_dec;
    logic       branch_taken;

    logic       mem_req_c;
    logic       mem_we_c;
    logic       adr_src_c;
    logic       ir_write_c;
    logic       pc_write_c;
    logic       reg_write_c;
    logic [1:0] alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] result_src_c;
    logic [1:0] imm_src_c;
    logic       instr_done_c;
    logic       illegal_c;

    riscv_alu_dec u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .alu_control (alu_control_dec)
    );

    // Only BEQ and BNE can redirect the PC; other funct3 codes fall through.
    always_comb begin
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = ~zero;
            default: branch_taken = 1'b0;
        endcase
    end

    // State register; reset parks the FSM in FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; memory states hold until mem_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Per-state datapath controls before the reset gate.
    always_comb begin
        mem_req_c    = 1'b0;
        mem_we_c     = 1'b0;
        adr_src_c    = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_RS2;
        result_src_c = RES_ALUOUT;
        imm_src_c    = IMM_I;
        instr_done_c = 1'b0;
        illegal_c    = 1'b0;
        alu_op       = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req_c    = 1'b1;
                alu_src_a_c  = SRCA_PC;
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALU;
                ir_write_c   = mem_ready;
                pc_write_c   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
                imm_src_c   = IMM_B;
                if (!is_supported(opcode)) begin
                    illegal_c    = 1'b1;
                    instr_done_c = 1'b1;
                end
            end
            S_MEMADR: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                imm_src_c   = (opcode == OP_LOAD) ? IMM_I : IMM_S;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
            end
            S_MEMWB: begin
                result_src_c = RES_MEMDATA;
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_c    = 1'b1;
                mem_we_c     = 1'b1;
                adr_src_c    = 1'b1;
                instr_done_c = mem_ready;
            end
            S_EXECR: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_RS2;
                alu_op      = ALUOP_RTYPE;
            end
            S_EXECI: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                imm_src_c   = IMM_I;
                alu_op      = ALUOP_ITYPE;
            end
            S_ALUWB: begin
                result_src_c = RES_ALUOUT;
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_c  = SRCA_RS1;
                alu_src_b_c  = SRCB_RS2;
                alu_op       = ALUOP_SUB;
                result_src_c = RES_ALUOUT;
                pc_write_c   = branch_taken;
                instr_done_c = 1'b1;
            end
            S_JAL: begin
                alu_src_a_c  = SRCA_OLDPC;
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALUOUT;
                pc_write_c   = 1'b1;
            end
            default: begin
                mem_req_c = 1'b0;
            end
        endcase
    end

    // Reset is applied combinationally so strobes drop the instant it asserts.
    always_comb begin
        mem_req     = reset & mem_req_c;
        mem_we      = reset & mem_we_c;
        adr_src     = reset & adr_src_c;
        ir_write    = reset & ir_write_c;
        pc_write    = reset & pc_write_c;
        reg_write   = reset & reg_write_c;
        instr_done  = reset & instr_done_c;
        illegal     = reset & illegal_c;
        alu_src_a   = reset ? alu_src_a_c     : 2'b00;
        alu_src_b   = reset ? alu_src_b_c     : 2'b00;
        result_src  = reset ? result_src_c    : 2'b00;
        imm_src     = reset ? imm_src_c       : 2'b00;
        alu_control = reset ? alu_control_dec : 3'b000;
    end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Bench for riscv_multicycle_ctrl: per-instruction expected output traces are
// built from the instruction class, memory wait counts and branch outcome,
// then compared cycle by cycle against the DUT.
module tb_riscv_multicycle_ctrl;
    import riscv_multicycle_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
    logic [2:0] alu_control;
    logic       instr_done, illegal;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] alu;
        logic [1:0] res;
        logic [1:0] imm;
        logic       done;
        logic       ill;
    } outs_t;

    typedef struct {
        outs_t e;
        logic  rdy;
        logic  z;
    } cyc_t;

    outs_t obs;
    cyc_t  plan[$];
    int    checks   = 0;
    int    failures = 0;

    assign obs = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, alu_control, result_src, imm_src,
                  instr_done, illegal};

    riscv_multicycle_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .result_src  (result_src),
        .imm_src     (imm_src),
        .instr_done  (instr_done),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_outs(input string tag, input outs_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input outs_t e, input logic rdy, input logic z);
        cyc_t c;
        c.e   = e;
        c.rdy = rdy;
        c.z   = z;
        plan.push_back(c);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // ALU code a register or immediate instruction should produce.
    function automatic logic [2:0] exp_alu(input bit is_r, input logic [2:0] f3, input logic f7);
        if (is_r) begin
            if (f3 == 3'b000) return f7 ? 3'b001 : 3'b000;
            if (f3 == 3'b010) return 3'b101;
            if (f3 == 3'b110) return 3'b011;
            if (f3 == 3'b111) return 3'b010;
            return 3'b000;
        end
        return (f3 == 3'b010) ? 3'b101 : 3'b000;
    endfunction

    function automatic outs_t fetch_vec(input logic ready);
        outs_t e = '0;
        e.mem_req  = 1'b1;
        e.b        = 2'b10;
        e.res      = 2'b10;
        e.ir_write = ready;
        e.pc_write = ready;
        return e;
    endfunction

    function automatic outs_t writeback_vec(input logic [1:0] res);
        outs_t e = '0;
        e.res       = res;
        e.reg_write = 1'b1;
        e.done      = 1'b1;
        return e;
    endfunction

    // Builds the expected trace of one instruction and plays it against the DUT.
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic zb, input int fw, input int mw);
        outs_t e;
        bit    taken;
        plan.delete();
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
        for (int i = 0; i <= fw; i++) push(fetch_vec(i == fw), i == fw, rbit());
        e = '0;
        e.a = 2'b01; e.b = 2'b01; e.imm = 2'b10;
        case (op)
            OP_RTYPE, OP_ITYPE: begin
                push(e, rbit(), rbit());
                e = '0;
                e.a   = 2'b10;
                e.b   = (op == OP_RTYPE) ? 2'b00 : 2'b01;
                e.alu = exp_alu(op == OP_RTYPE, f3, f7);
                push(e, rbit(), rbit());
                push(writeback_vec(2'b00), rbit(), rbit());
            end
            OP_LOAD, OP_STORE: begin
                push(e, rbit(), rbit());
                e = '0;
                e.a = 2'b10; e.b = 2'b01;
                e.imm = (op == OP_LOAD) ? 2'b00 : 2'b01;
                push(e, rbit(), rbit());
                for (int i = 0; i <= mw; i++) begin
                    e = '0;
                    e.mem_req = 1'b1;
                    e.adr_src = 1'b1;
                    e.mem_we  = (op == OP_STORE);
                    e.done    = (op == OP_STORE) && (i == mw);
                    push(e, i == mw, rbit());
                end
                if (op == OP_LOAD) push(writeback_vec(2'b01), rbit(), rbit());
            end
            OP_BRANCH: begin
                push(e, rbit(), rbit());
                taken = ((f3 == 3'b000) && zb) || ((f3 == 3'b001) && !zb);
                e = '0;
                e.a = 2'b10; e.alu = 3'b001; e.pc_write = taken; e.done = 1'b1;
                push(e, rbit(), zb);
            end
            OP_JAL: begin
                push(e, rbit(), rbit());
                e = '0;
                e.a = 2'b01; e.b = 2'b10; e.pc_write = 1'b1;
                push(e, rbit(), rbit());
                push(writeback_vec(2'b00), rbit(), rbit());
            end
            default: begin
                e.done = 1'b1;
                e.ill  = 1'b1;
                push(e, rbit(), rbit());
            end
        endcase
        foreach (plan[k]) begin
            mem_ready = plan[k].rdy;
            zero      = plan[k].z;
            @(negedge clk);
            check_outs($sformatf("%s_c%0d", name, k + 1), plan[k].e);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] ops [7];
        logic [6:0] op;
        outs_t      e;
        ops = '{OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, 7'h7F};

        reset = 1'b0; opcode = OP_RTYPE; funct3 = 3'b000; funct7_5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b1;
        #2;
        check_outs("reset_t0", '0);
        repeat (2) begin
            @(negedge clk);
            check_outs("reset_hold", '0);
        end
        reset = 1'b1; mem_ready = 1'b0;
        #1;
        check_outs("first_fetch", fetch_vec(1'b0));
        @(posedge clk); #1;

        run_instr("add",     OP_RTYPE,  3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("sub",     OP_RTYPE,  3'b000, 1'b1, 1'b0, 0, 0);
        run_instr("slt",     OP_RTYPE,  3'b010, 1'b0, 1'b0, 0, 0);
        run_instr("or",      OP_RTYPE,  3'b110, 1'b0, 1'b0, 0, 0);
        run_instr("and",     OP_RTYPE,  3'b111, 1'b0, 1'b0, 0, 0);
        run_instr("slti",    OP_ITYPE,  3'b010, 1'b0, 1'b0, 0, 0);
        run_instr("addi",    OP_ITYPE,  3'b000, 1'b1, 1'b0, 0, 0);
        run_instr("lw_w3",   OP_LOAD,   3'b010, 1'b0, 1'b0, 0, 3);
        run_instr("sw",      OP_STORE,  3'b010, 1'b0, 1'b0, 0, 0);
        run_instr("sw_w2",   OP_STORE,  3'b010, 1'b0, 1'b0, 0, 2);
        run_instr("beq_z1",  OP_BRANCH, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr("beq_z0",  OP_BRANCH, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("bne_z1",  OP_BRANCH, 3'b001, 1'b0, 1'b1, 0, 0);
        run_instr("bne_z0",  OP_BRANCH, 3'b001, 1'b0, 1'b0, 0, 0);
        run_instr("blt_nt",  OP_BRANCH, 3'b100, 1'b0, 1'b0, 0, 0);
        run_instr("ill_7f",  7'h7F,     3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("jal",     OP_JAL,    3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("add_fw2", OP_RTYPE,  3'b000, 1'b0, 1'b0, 2, 0);

        for (int n = 0; n < 50; n++) begin
            op = ops[$urandom_range(0, 6)];
            if (op == 7'h7F) begin
                op = 7'($urandom);
                if (is_supported(op)) op = 7'h7F;
            end
            run_instr($sformatf("rnd%0d", n), op, 3'($urandom), rbit(), rbit(),
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Reset asserted while a load waits in its memory read.
        opcode = OP_LOAD; funct3 = 3'b010; funct7_5 = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check_outs("abort_fetch", fetch_vec(1'b1));
        @(posedge clk); #1;
        repeat (2) begin
            mem_ready = rbit();
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        e = '0; e.mem_req = 1'b1; e.adr_src = 1'b1;
        check_outs("abort_memread", e);
        #1 reset = 1'b0;
        #1;
        check_outs("abort_async_drop", '0);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        check_outs("abort_hold", '0);
        @(negedge clk);
        reset = 1'b0;
        check_outs("abort_hold2", '0);
        reset = 1'b1; mem_ready = 1'b0;
        #1;
        check_outs("abort_release_fetch", fetch_vec(1'b0));
        @(posedge clk); #1;
        run_instr("after_abort", OP_RTYPE, 3'b000, 1'b1, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
